// File: rtl/sobel_edge_engine_if.sv
// ----------------------------------------------------------------------------
// sobel_edge_engine_if
//   Groups the start/status handshake and the two BRAM ports of the Sobel
//   edge engine.
//   master : the engine side (drives addresses, results and status)
//   slave  : the environment side (drives start and source read data)
//   Signals:
//     start     environment -> engine  frame start request (level or pulse)
//     src_addr  engine -> source BRAM  read address
//     src_data  source BRAM -> engine  read data, one-cycle read latency
//     dst_addr  engine -> result BRAM  write address
//     dst_data  engine -> result BRAM  result pixel
//     dst_we    engine -> result BRAM  write enable
//     busy      engine -> environment  frame in progress
//     done      engine -> environment  one-cycle end-of-frame pulse
//     ready     engine -> environment  result frame valid
// ----------------------------------------------------------------------------
interface sobel_edge_engine_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_data;
  logic              dst_we;
  logic              busy;
  logic              done;
  logic              ready;

  modport master (
    input  start, src_data,
    output src_addr, dst_addr, dst_data, dst_we, busy, done, ready
  );

  modport slave (
    output start, src_data,
    input  src_addr, dst_addr, dst_data, dst_we, busy, done, ready
  );
endinterface

// File: rtl/sobel_edge_engine.sv
// ----------------------------------------------------------------------------
// sobel_edge_engine
//   Raster-reads an H x V 8-bit grayscale frame from a source BRAM (one pixel
//   per clock) and writes |Gx|+|Gy| Sobel magnitudes, saturated to 255, into a
//   result BRAM. Result pixel (x,y) holds the magnitude of the window centred
//   on (x-1,y-1); rows 0-1 and columns 0-1 are written as 0.
//   Pipeline: BRAM read -> window/line-buffer update -> kernel register, so a
//   result write trails its source address by exactly 3 cycles.
//   Optional build macro: SOBEL_THRESH_EN -- binarise the magnitude against
//   THRESH (255 when mag >= THRESH, else 0).
//   Ports:
//     clk    system clock, posedge
//     rst_n  asynchronous active-low reset
//     bus    sobel_edge_engine_if.master (start, src_*, dst_*, busy/done/ready)
// ----------------------------------------------------------------------------
module sobel_edge_engine #(
  parameter int H      = 500,
  parameter int V      = 500,
  parameter int ADDR_W = 19,
  parameter int THRESH = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sobel_edge_engine_if.master   bus
);
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H * V - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Absolute value of an 11-bit signed gradient (range never reaches -1024).
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    if (v[10]) begin
      abs11 = 11'(-v);
    end else begin
      abs11 = 11'(v);
    end
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [1:0]        drain_q, drain_d;
  logic              busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  // Stage 1: coordinates of the pixel currently on src_data.
  logic              v1_q, v1_d;
  logic [XW-1:0]     x1_q, x1_d;
  logic [YW-1:0]     y1_q, y1_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  // Stage 2: coordinates of the newest pixel in the window.
  logic              v2_q, v2_d;
  logic [XW-1:0]     x2_q, x2_d;
  logic [YW-1:0]     y2_q, y2_d;
  logic [ADDR_W-1:0] a2_q, a2_d;
  // Window [row][col]: row 0 = line y-2, col 2 = newest column.
  logic [2:0][2:0][7:0] win_q, win_d;
  // Stage 3: registered result write.
  logic              we_q, we_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [7:0]        ddata_q, ddata_d;
  // Line buffers: lb1 holds line y-1, lb0 holds line y-2 (never cleared).
  logic [7:0]        lb0_q [H];
  logic [7:0]        lb1_q [H];

  logic [9:0]        gx_p_s, gx_n_s, gy_p_s, gy_n_s;
  logic signed [10:0] gx_s, gy_s;
  logic [11:0]       mag_s;
  logic [7:0]        pix_s;

  // Frame sequencer: raster counters, drain timer and status flags.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          n_d     = '0;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (n_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          n_d = n_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Three cycles let the last pixel leave the pipeline.
        if (drain_q == 2'd2) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        n_d     = '0;
        x_d     = '0;
        y_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pipeline stages 1 and 2: coordinate tracking and window shift.
  always_comb begin
    v1_d  = (state_q == S_RUN);
    x1_d  = x_q;
    y1_d  = y_q;
    a1_d  = n_q;
    v2_d  = v1_q;
    x2_d  = x1_q;
    y2_d  = y1_q;
    a2_d  = a1_q;
    win_d = win_q;
    if (v1_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_q[x1_q];
      win_d[1][2] = lb1_q[x1_q];
      win_d[2][2] = bus.src_data;
    end else begin
      win_d = win_q;
    end
  end

  // Kernel, saturation/binarisation and border masking for stage 3.
  always_comb begin
    gx_p_s = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
    gx_n_s = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
    gy_p_s = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
    gy_n_s = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
    gx_s   = $signed({1'b0, gx_p_s}) - $signed({1'b0, gx_n_s});
    gy_s   = $signed({1'b0, gy_p_s}) - $signed({1'b0, gy_n_s});
    mag_s  = {1'b0, abs11(gx_s)} + {1'b0, abs11(gy_s)};
`ifdef SOBEL_THRESH_EN
    if (mag_s >= 12'(THRESH)) begin
      pix_s = 8'd255;
    end else begin
      pix_s = 8'd0;
    end
`else
    if (mag_s > 12'd255) begin
      pix_s = 8'd255;
    end else begin
      pix_s = mag_s[7:0];
    end
`endif
    we_d    = v2_q;
    daddr_d = a2_q;
    // Windows with x<2 or y<2 straddle a line/frame wrap and are forced to 0.
    if (v2_q && (x2_q >= XW'(2)) && (y2_q >= YW'(2))) begin
      ddata_d = pix_s;
    end else begin
      ddata_d = 8'd0;
    end
  end

`ifndef SOBEL_THRESH_EN
  // THRESH only matters in the binarising build.
  logic [11:0] thresh_unused_s;
  assign thresh_unused_s = 12'(THRESH);
`endif

  // State, pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      v1_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      a1_q    <= '0;
      v2_q    <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
      a2_q    <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      daddr_q <= '0;
      ddata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      v1_q    <= v1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      a1_q    <= a1_d;
      v2_q    <= v2_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      a2_q    <= a2_d;
      win_q   <= win_d;
      we_q    <= we_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end

  // Line buffers, read-before-write: lb1 takes the new pixel, lb0 the old lb1.
  always_ff @(posedge clk) begin
    if (v1_q) begin
      lb1_q[x1_q] <= bus.src_data;
      lb0_q[x1_q] <= lb1_q[x1_q];
    end
  end

  assign bus.src_addr = n_q;
  assign bus.dst_addr = daddr_q;
  assign bus.dst_data = ddata_q;
  assign bus.dst_we   = we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_sobel_edge_engine.sv
// ----------------------------------------------------------------------------
// tb_sobel_edge_engine
//   Directed bench for an 8x8 frame. Source BRAM and result BRAM are modelled
//   here; each frame's result cells are compared with hand-derived values.
//   Build with SOBEL_THRESH_EN defined to check the binarising variant.
// ----------------------------------------------------------------------------
module tb_sobel_edge_engine;
  localparam int H  = 8;
  localparam int V  = 8;
  localparam int AW = 6;
  localparam int N  = H * V;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b1;

  always #5 clk = ~clk;

  sobel_edge_engine_if #(.ADDR_W(AW)) bus ();

  sobel_edge_engine #(.H(H), .V(V), .ADDR_W(AW), .THRESH(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] src_mem [N];
  logic [7:0] dst_mem [N];
  int         hits    [N];
  int         we_cnt, done_cnt, order_err;
  int         n_vec = 0;
  int         n_bad = 0;

  // Source BRAM: one-cycle read latency.
  always @(posedge clk) begin
    bus.src_data <= src_mem[bus.src_addr];
  end

  // Result BRAM plus write/done bookkeeping.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        dst_mem[i] <= 8'hA5;
        hits[i]    <= 0;
      end
      we_cnt    <= 0;
      done_cnt  <= 0;
      order_err <= 0;
    end else begin
      if (bus.dst_we) begin
        dst_mem[bus.dst_addr] <= bus.dst_data;
        hits[bus.dst_addr]    <= hits[bus.dst_addr] + 1;
        if (int'(bus.dst_addr) != we_cnt) order_err <= order_err + 1;
        we_cnt <= we_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
    end
  end

  typedef struct {
    int pat;        // source pattern id
    bit mid_start;  // re-pulse start in RUN cycle 10
    int inner;      // expected value of every x>=2,y>=2 cell for ramps
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int pat);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        case (pat)
          1:       src_mem[y*H+x] = 8'd128;
          2:       src_mem[y*H+x] = (x < 4) ? 8'd0 : 8'd255;
          3:       src_mem[y*H+x] = (x == 4 && y == 4) ? 8'd10 : 8'd0;
          4:       src_mem[y*H+x] = 8'(10 * x);
          5:       src_mem[y*H+x] = 8'(20 * y);
          6:       src_mem[y*H+x] = 8'(10 * x + 20 * y);
          7:       src_mem[y*H+x] = 8'(70 - 10 * x);
          8:       src_mem[y*H+x] = 8'(140 - 20 * y);
          default: src_mem[y*H+x] = 8'd0;
        endcase
      end
    end
  endtask

  function automatic int exp_cell(input int pat, input int inner, input int x, input int y);
    int p20;
`ifdef SOBEL_THRESH_EN
    p20 = 0;
`else
    p20 = 20;
`endif
    if (x < 2 || y < 2) return 0;
    case (pat)
      1: return 0;
      2: return (x == 4 || x == 5) ? 255 : 0;
      3: return (x >= 4 && x <= 6 && y >= 4 && y <= 6 && !(x == 5 && y == 5)) ? p20 : 0;
      default: return inner;
    endcase
  endfunction

  task automatic run_frame(input vec_t v);
    int k;
    int ready_err;
    int busy_err;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    bus.start = 1'b1;
    k = 0; ready_err = 0; busy_err = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) bus.start = 1'b0;
      if (v.mid_start && k == 11) bus.start = 1'b1;
      if (k == 12) bus.start = 1'b0;
      if (bus.done) break;
      if (bus.ready) ready_err++;
      if (!bus.busy) busy_err++;
    end
    check($sformatf("pat%0d done_latency", v.pat), k, 68);
    check($sformatf("pat%0d ready_low_in_frame", v.pat), ready_err, 0);
    check($sformatf("pat%0d busy_high_in_frame", v.pat), busy_err, 0);
    check($sformatf("pat%0d busy_at_done", v.pat), int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    check($sformatf("pat%0d done_count", v.pat), done_cnt, 1);
    check($sformatf("pat%0d we_count", v.pat), we_cnt, N);
    check($sformatf("pat%0d write_order", v.pat), order_err, 0);
    check($sformatf("pat%0d ready_after", v.pat), int'(bus.ready), 1);
    begin
      int not_once;
      not_once = 0;
      for (int i = 0; i < N; i++) if (hits[i] != 1) not_once++;
      check($sformatf("pat%0d written_once", v.pat), not_once, 0);
    end
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        check($sformatf("pat%0d cell(%0d,%0d)", v.pat, x, y),
              int'(dst_mem[y*H+x]), exp_cell(v.pat, v.inner, x, y));
      end
    end
  endtask

  vec_t vecs [8];

  initial begin
    int k;
`ifdef SOBEL_THRESH_EN
    vecs[0] = '{1, 1'b0, 0};   vecs[1] = '{2, 1'b0, 0};
    vecs[2] = '{3, 1'b0, 0};   vecs[3] = '{1, 1'b1, 0};
    vecs[4] = '{4, 1'b0, 0};   vecs[5] = '{5, 1'b0, 255};
    vecs[6] = '{6, 1'b1, 255}; vecs[7] = '{7, 1'b0, 0};
`else
    vecs[0] = '{1, 1'b0, 0};   vecs[1] = '{2, 1'b0, 0};
    vecs[2] = '{3, 1'b0, 0};   vecs[3] = '{1, 1'b1, 0};
    vecs[4] = '{4, 1'b0, 80};  vecs[5] = '{5, 1'b0, 160};
    vecs[6] = '{6, 1'b1, 240}; vecs[7] = '{7, 1'b0, 80};
`endif
    bus.start = 1'b0;
    load(0);
    repeat (3) @(negedge clk);
    check("reset src_addr", int'(bus.src_addr), 0);
    check("reset dst_we", int'(bus.dst_we), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset ready", int'(bus.ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      load(vecs[i].pat);
      run_frame(vecs[i]);
    end

    // Negative vertical ramp, outside the table's slots.
    load(8);
`ifdef SOBEL_THRESH_EN
    run_frame('{8, 1'b0, 255});
`else
    run_frame('{8, 1'b0, 160});
`endif

    // Reset in the middle of a frame, then a fresh all-128 frame.
    load(2);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 0;
    while (k < 100 && int'(bus.src_addr) != 30) begin
      @(negedge clk);
      k++;
    end
    check("midreset reached n=30", int'(bus.src_addr), 30);
    check("midreset busy before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("midreset dst_we", int'(bus.dst_we), 0);
    check("midreset busy", int'(bus.busy), 0);
    check("midreset ready", int'(bus.ready), 0);
    check("midreset done", int'(bus.done), 0);
    check("midreset src_addr", int'(bus.src_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset stays idle", int'(bus.busy), 0);
    load(1);
    run_frame('{1, 1'b0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
